sl_transmitter: RTL and testbench

//  Serial-line (SL) transmitter; upstream partner of SL_receiver. Serialises a 1..32-bit word onto the
//  two-wire SL bus (zeroes line, ones line; idle high). Appends the per-line parity pair and the stop

---
 rtl/sl_transmitter.sv | 238 +++++++++++++++++++++++
 tb/tb_sl_transmitter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sl_transmitter.sv
// Two-wire serial-line transmitter: LSB-first data bits, per-line parity pair and stop pattern.
// Register-style config/data/status interface, all logic on the rising edge of clk.
module sl_transmitter #(
  parameter int CLK_PER_HALF_BIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_enable,
  input  logic [15:0] wr_config_w,
  output logic [15:0] r_config_w,
  input  logic        data_wr,
  input  logic [31:0] data_w,
  output logic [15:0] status_w,
  output logic        serial_line_zeroes_o,
  output logic        serial_line_ones_o
);

  localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LEAD  = 4'd1,
    S_BIT   = 4'd2,
    S_TAIL  = 4'd3,
    S_PLEAD = 4'd4,
    S_PAR   = 4'd5,
    S_PGAP  = 4'd6,
    S_STOP  = 4'd7,
    S_END   = 4'd8
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic [5:0]      bit_idx_r;
  logic [5:0]      len_r;
  logic            pinv_r;
  logic [5:0]      len_sh_r;
  logic [31:0]     shift_r;
  logic            par_zeroes_r;
  logic            par_ones_r;
  logic            busy_r;
  logic            done_r;
  logic            cfg_err_r;
  logic            overrun_r;
  logic            zeroes_r;
  logic            ones_r;

  logic [5:0]      wr_len_s;
  logic            cfg_ok_s;
  logic [5:0]      eff_len_s;
  logic            eff_pinv_s;
  logic            p1_s;
  logic            p0_s;
  logic            unused_cfg_bits_s;

  function automatic logic [31:0] len_mask(input logic [5:0] len);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      m[i] = (6'(i) < len);
    end
    return m;
  endfunction

  function automatic logic ones_parity(input logic [31:0] d, input logic [5:0] len);
    return ^(d & len_mask(len));
  endfunction

  // A same-cycle valid config write takes effect for a frame accepted in that cycle.
  always_comb begin
    wr_len_s = wr_config_w[6:1];
    cfg_ok_s = (wr_len_s != 6'd0) && (wr_len_s <= 6'd32);
    if (wr_enable && cfg_ok_s) begin
      eff_len_s  = wr_len_s;
      eff_pinv_s = wr_config_w[0];
    end else begin
      eff_len_s  = len_r;
      eff_pinv_s = pinv_r;
    end
    p1_s = ones_parity(data_w, eff_len_s);
    // zero count = LEN - ones, so its parity is LEN[0] ^ P1; P0 inverts that.
    p0_s = ~(eff_len_s[0] ^ p1_s);
  end

  assign unused_cfg_bits_s = ^wr_config_w[15:7];

  // Config/status registers plus the frame sequencer with registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      timer_r      <= {TW{1'b0}};
      bit_idx_r    <= 6'd0;
      len_r        <= 6'd32;
      pinv_r       <= 1'b0;
      len_sh_r     <= 6'd32;
      shift_r      <= 32'h0000_0000;
      par_zeroes_r <= 1'b1;
      par_ones_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      overrun_r    <= 1'b0;
      zeroes_r     <= 1'b1;
      ones_r       <= 1'b1;
    end else begin
      if (wr_enable) begin
        if (cfg_ok_s) begin
          len_r     <= wr_len_s;
          pinv_r    <= wr_config_w[0];
          cfg_err_r <= 1'b0;
        end else begin
          cfg_err_r <= 1'b1;
        end
      end
      if (data_wr && busy_r) begin
        overrun_r <= 1'b1;
      end

      case (state_r)
        S_IDLE: begin
          zeroes_r <= 1'b1;
          ones_r   <= 1'b1;
          if (data_wr) begin
            state_r      <= S_LEAD;
            timer_r      <= {TW{1'b0}};
            bit_idx_r    <= 6'd0;
            len_sh_r     <= eff_len_s;
            shift_r      <= data_w;
            par_zeroes_r <= p0_s ^ eff_pinv_s;
            par_ones_r   <= p1_s ^ eff_pinv_s;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
          end
        end
        S_LEAD: begin
          if (timer_r == HALF_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_BIT;
            zeroes_r <= shift_r[0];
            ones_r   <= ~shift_r[0];
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_BIT: begin
          if (timer_r == FULL_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_TAIL;
            zeroes_r <= 1'b1;
            ones_r   <= 1'b1;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_TAIL: begin
          if (timer_r == HALF_LAST) begin
            timer_r <= {TW{1'b0}};
            if (bit_idx_r == len_sh_r - 6'd1) begin
              state_r <= S_PLEAD;
            end else begin
              state_r   <= S_LEAD;
              bit_idx_r <= bit_idx_r + 6'd1;
              shift_r   <= {1'b0, shift_r[31:1]};
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_PLEAD: begin
          if (timer_r == HALF_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_PAR;
            zeroes_r <= par_zeroes_r;
            ones_r   <= par_ones_r;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_PAR: begin
          if (timer_r == FULL_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_PGAP;
            zeroes_r <= 1'b1;
            ones_r   <= 1'b1;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_PGAP: begin
          if (timer_r == FULL_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_STOP;
            zeroes_r <= 1'b0;
            ones_r   <= 1'b0;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_STOP: begin
          if (timer_r == FULL_LAST) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= S_END;
            zeroes_r <= 1'b1;
            ones_r   <= 1'b1;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        S_END: begin
          if (timer_r == HALF_LAST) begin
            timer_r <= {TW{1'b0}};
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          timer_r  <= {TW{1'b0}};
          busy_r   <= 1'b0;
          zeroes_r <= 1'b1;
          ones_r   <= 1'b1;
        end
      endcase
    end
  end

  assign r_config_w           = {9'b0_0000_0000, len_r, pinv_r};
  assign status_w             = {12'h000, overrun_r, cfg_err_r, done_r, busy_r};
  assign serial_line_zeroes_o = zeroes_r;
  assign serial_line_ones_o   = ones_r;

endmodule

// File: tb/tb_sl_transmitter.sv
// Self-checking bench for sl_transmitter: directed steps with random data, each frame compared
// cycle by cycle against a waveform built from the line protocol rules.
module tb_sl_transmitter;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_enable;
  logic [15:0] wr_config_w;
  logic [15:0] r_config_w;
  logic        data_wr;
  logic [31:0] data_w;
  logic [15:0] status_w;
  logic        serial_line_zeroes_o;
  logic        serial_line_ones_o;

  int tests = 0;
  int fails = 0;

  logic [5:0] m_len;
  logic       m_pinv;
  logic       m_cfg_err;
  logic       m_overrun;
  logic       m_done;
  logic [1:0] exp_q[$];

  sl_transmitter #(.CLK_PER_HALF_BIT(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_enable(wr_enable),
    .wr_config_w(wr_config_w),
    .r_config_w(r_config_w),
    .data_wr(data_wr),
    .data_w(data_w),
    .status_w(status_w),
    .serial_line_zeroes_o(serial_line_zeroes_o),
    .serial_line_ones_o(serial_line_ones_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status(input logic busy);
    return {12'h000, m_overrun, m_cfg_err, m_done, busy};
  endfunction

  function automatic logic [15:0] exp_config();
    return {9'h000, m_len, m_pinv};
  endfunction

  task automatic model_reset();
    m_len = 6'd32; m_pinv = 1'b0; m_cfg_err = 1'b0; m_overrun = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_cfg_write(input logic [5:0] len, input logic pinv);
    if (len >= 6'd1 && len <= 6'd32) begin
      m_len = len; m_pinv = pinv; m_cfg_err = 1'b0;
    end else begin
      m_cfg_err = 1'b1;
    end
  endtask

  // Expected {zeroes, ones} per clock from the first LEAD cycle to the last END cycle.
  task automatic build_wave(input logic [31:0] d);
    int ones;
    int zeros;
    logic p0;
    logic p1;
    exp_q.delete();
    ones = 0;
    zeros = 0;
    for (int b = 0; b < int'(m_len); b++) begin
      repeat (H) exp_q.push_back(2'b11);
      repeat (2 * H) exp_q.push_back(d[b] ? 2'b10 : 2'b01);
      repeat (H) exp_q.push_back(2'b11);
      if (d[b]) ones++; else zeros++;
    end
    p0 = ((zeros % 2) == 0);
    p1 = ((ones % 2) == 1);
    repeat (H) exp_q.push_back(2'b11);
    repeat (2 * H) exp_q.push_back({p0 ^ m_pinv, p1 ^ m_pinv});
    repeat (2 * H) exp_q.push_back(2'b11);
    repeat (2 * H) exp_q.push_back(2'b00);
    repeat (H) exp_q.push_back(2'b11);
  endtask

  task automatic cfg_write(input logic [5:0] len, input logic pinv, input string tag);
    wr_enable = 1'b1;
    wr_config_w = {9'h1A5, len, pinv};
    step();
    wr_enable = 1'b0;
    model_cfg_write(len, pinv);
    check({tag, " config readback"}, 32'(r_config_w), 32'(exp_config()));
    check({tag, " status"}, 32'(status_w), 32'(exp_status(1'b0)));
  endtask

  task automatic run_frame(input logic [31:0] d, input logic do_cfg, input logic [5:0] clen,
                           input logic cpinv, input logic mid_dw, input logic mid_cfg,
                           input logic [5:0] mlen, input logic mpinv, input string tag);
    int f;
    int mism;
    int first_bad;
    if (do_cfg) begin
      wr_enable = 1'b1;
      wr_config_w = {9'h000, clen, cpinv};
      model_cfg_write(clen, cpinv);
    end
    data_wr = 1'b1;
    data_w = d;
    build_wave(d);
    m_done = 1'b0;
    m_overrun = 1'b0;
    step();
    wr_enable = 1'b0;
    data_wr = 1'b0;
    f = exp_q.size();
    mism = 0;
    first_bad = -1;
    for (int k = 0; k < f; k++) begin
      if (k > 0) step();
      if ({serial_line_zeroes_o, serial_line_ones_o} !== exp_q[k] || status_w !== exp_status(1'b1)) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == f / 2) begin
        if (mid_dw) begin
          data_wr = 1'b1;
          data_w = ~d;
          m_overrun = 1'b1;
        end
        if (mid_cfg) begin
          wr_enable = 1'b1;
          wr_config_w = {9'h000, mlen, mpinv};
          model_cfg_write(mlen, mpinv);
        end
      end
      if (k == f / 2 + 1) begin
        data_wr = 1'b0;
        wr_enable = 1'b0;
        if (mid_cfg) check({tag, " mid-frame config readback"}, 32'(r_config_w), 32'(exp_config()));
      end
    end
    tests++;
    assert (mism === 0) else begin
      fails++;
      $error("FAIL %s frame: %0d bad cycles, first at cycle %0d (observed lines %b status %h, expected lines %b)",
             tag, mism, first_bad, {serial_line_zeroes_o, serial_line_ones_o}, status_w,
             (first_bad >= 0) ? exp_q[first_bad] : 2'b11);
    end
    step();
    m_done = 1'b1;
    check({tag, " completion status"}, 32'(status_w), 32'(exp_status(1'b0)));
    check({tag, " idle lines"}, 32'({serial_line_zeroes_o, serial_line_ones_o}), 32'(2'b11));
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  len;
    logic        pinv;

    rst_n = 1'b0; wr_enable = 1'b0; wr_config_w = 16'h0000; data_wr = 1'b0; data_w = 32'h0;
    model_reset();
    step();
    step();
    check("reset lines", 32'({serial_line_zeroes_o, serial_line_ones_o}), 32'(2'b11));
    check("reset config", 32'(r_config_w), 32'h0000_0040);
    check("reset status", 32'(status_w), 32'h0000_0000);
    rst_n = 1'b1;
    step();

    cfg_write(6'd8, 1'b0, "len8");
    run_frame(32'h0000_00A5, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "a5");

    // Back-to-back random frames, config written in the same cycle as each load.
    for (int i = 0; i < 20; i++) begin
      len = 6'($urandom_range(32, 1));
      pinv = 1'($urandom_range(1, 0));
      d = $urandom();
      run_frame(d, 1'b1, len, pinv, 1'b0, 1'b0, 6'd0, 1'b0, "random");
    end

    cfg_write(6'd0, 1'b1, "len0");
    cfg_write(6'd33, 1'b1, "len33");
    cfg_write(6'd32, 1'b0, "len32");
    run_frame(32'hFFFF_FFFF, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "all-ones");

    cfg_write(6'd4, 1'b0, "len4");
    run_frame($urandom(), 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd6, 1'b1, "overrun");
    run_frame($urandom(), 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "after-overrun");

    d = $urandom();
    data_w = d;
    data_wr = 1'b1;
    step();
    data_wr = 1'b0;
    repeat (H + 2) step();
    check("in-bit lines", 32'({serial_line_zeroes_o, serial_line_ones_o}), 32'(d[0] ? 2'b10 : 2'b01));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    check("mid-frame reset lines", 32'({serial_line_zeroes_o, serial_line_ones_o}), 32'(2'b11));
    check("mid-frame reset status", 32'(status_w), 32'h0000_0000);
    check("mid-frame reset config", 32'(r_config_w), 32'h0000_0040);
    step();
    check("post-reset status", 32'(status_w), 32'h0000_0000);
    run_frame($urandom(), 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
